// File: rtl/ad_ip_jesd204_tpl_adc_pn_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ad_ip_jesd204_tpl_adc_pn_check                                 |
// | Purpose : per-channel PN9/PN23 checker with sync hysteresis, all-zero    |
// |           guard, restart on mode change and saturating error counter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ad_ip_jesd204_tpl_adc_pn_check #(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_PATH_WIDTH = 1,
  parameter int CHANNEL_WIDTH   = 16,
  parameter int OOS_THRESHOLD   = 16,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                                                adc_clk,
  input  logic                                                adc_rst,
  input  logic                                                adc_valid,
  input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] adc_data,
  input  logic [NUM_CHANNELS*4-1:0]                           pn_seq_sel,
  input  logic [NUM_CHANNELS-1:0]                             err_cnt_clr,
  output logic [NUM_CHANNELS-1:0]                             pn_err,
  output logic [NUM_CHANNELS-1:0]                             pn_oos,
  output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0]               pn_err_cnt
);

  localparam int BEAT_W = DATA_PATH_WIDTH * CHANNEL_WIDTH;
  localparam int HIST_W = 23;
  localparam int EXT_W  = HIST_W + BEAT_W;

  localparam logic [3:0] MODE_PN9  = 4'h0;
  localparam logic [3:0] MODE_PN23 = 4'h1;

  localparam logic [0:0] ST_OOS  = 1'b0;
  localparam logic [0:0] ST_SYNC = 1'b1;

  localparam logic [7:0]               CNT_LAST    = 8'(OOS_THRESHOLD - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [3:0]               sel;
    logic [3:0]               mode_q, mode_d;
    logic                     mode_chg;
    logic                     mode_en;
    logic [BEAT_W-1:0]        beat;
    logic [BEAT_W-1:0]        miss;
    logic [EXT_W-1:0]         ext;
    logic                     beat_match;
    logic [HIST_W-1:0]        hist_q, hist_d;
    logic                     hist_vld_q, hist_vld_d;
    logic                     s1_vld_q, s1_vld_d;
    logic                     s1_match_q, s1_match_d;
    logic [0:0]               state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     oos_q, oos_d;
    logic                     err_inc;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    assign sel      = pn_seq_sel[c*4 +: 4];
    assign mode_d   = sel;
    assign mode_chg = (sel != mode_q);
    assign mode_en  = (mode_q == MODE_PN9) || (mode_q == MODE_PN23);

    // beat[i] is the i-th bit on the wire: oldest sample first, MSB first.
    always_comb begin : beat_unpack
      beat = '0;
      for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
        for (int b = 0; b < CHANNEL_WIDTH; b++) begin
          beat[s*CHANNEL_WIDTH + CHANNEL_WIDTH - 1 - b] =
            adc_data[c*BEAT_W + s*CHANNEL_WIDTH + b];
        end
      end
    end

    // Time-ordered window: ext[k] for k < 23 is history (oldest at 0),
    // ext[23+i] is beat bit i, so bit i is predicted from ext[23+i-tap].
    assign ext = {beat, hist_q};

    always_comb begin : predict
      miss = '0;
      for (int i = 0; i < BEAT_W; i++) begin
        if (mode_q == MODE_PN23) begin
          miss[i] = beat[i] ^ ext[i] ^ ext[i+5];
        end else begin
          miss[i] = beat[i] ^ ext[i+14] ^ ext[i+18];
        end
      end
    end

    assign beat_match = ~|miss && |beat;

    always_comb begin : stage1
      hist_d     = hist_q;
      hist_vld_d = hist_vld_q;
      s1_vld_d   = s1_vld_q;
      s1_match_d = s1_match_q;
      if (adc_valid) begin
        hist_d = ext[BEAT_W +: HIST_W];
      end
      if (mode_chg) begin
        hist_vld_d = 1'b0;
        s1_vld_d   = 1'b0;
      end else if (adc_valid) begin
        hist_vld_d = mode_en;
        s1_vld_d   = hist_vld_q & mode_en;
        s1_match_d = beat_match;
      end
    end

    always_comb begin : stage2
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      oos_d     = oos_q;
      err_inc   = 1'b0;
      err_cnt_d = err_cnt_q;
      if (mode_chg || (adc_valid && !mode_en)) begin
        state_d = ST_OOS;
        cnt_d   = '0;
        err_d   = 1'b0;
        oos_d   = 1'b1;
      end else if (adc_valid) begin
        err_d = 1'b0;
        if (s1_vld_q) begin
          case (state_q)
            ST_OOS: begin
              if (!s1_match_q) begin
                cnt_d = '0;
              end else if (cnt_q == CNT_LAST) begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                oos_d   = 1'b0;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
            default: begin
              if (s1_match_q) begin
                cnt_d = '0;
              end else begin
                err_d   = 1'b1;
                err_inc = 1'b1;
                if (cnt_q == CNT_LAST) begin
                  state_d = ST_OOS;
                  cnt_d   = '0;
                  oos_d   = 1'b1;
                end else begin
                  cnt_d = cnt_q + 8'd1;
                end
              end
            end
          endcase
        end
      end
      // Clear wins over a coincident increment.
      if (err_cnt_clr[c]) begin
        err_cnt_d = '0;
      end else if (err_inc && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
        mode_q     <= sel;
        hist_q     <= '0;
        hist_vld_q <= 1'b0;
        s1_vld_q   <= 1'b0;
        s1_match_q <= 1'b0;
        state_q    <= ST_OOS;
        cnt_q      <= '0;
        err_q      <= 1'b0;
        oos_q      <= 1'b1;
        err_cnt_q  <= '0;
      end else begin
        mode_q     <= mode_d;
        hist_q     <= hist_d;
        hist_vld_q <= hist_vld_d;
        s1_vld_q   <= s1_vld_d;
        s1_match_q <= s1_match_d;
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        err_q      <= err_d;
        oos_q      <= oos_d;
        err_cnt_q  <= err_cnt_d;
      end
    end

    assign pn_err[c]                                = err_q;
    assign pn_oos[c]                                = oos_q;
    assign pn_err_cnt[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_check.sv
`default_nettype none
// Testbench for ad_ip_jesd204_tpl_adc_pn_check: PN generators drive both
// channels, a scoreboard queue carries per-beat match results to stage 2.
module tb_ad_ip_jesd204_tpl_adc_pn_check;

  localparam int NCH    = 2;
  localparam int DPW    = 2;
  localparam int CW     = 16;
  localparam int TH     = 4;
  localparam int ECW    = 4;
  localparam int BW     = DPW * CW;
  localparam int EC_MAX = (1 << ECW) - 1;

  logic                  adc_clk = 1'b0;
  logic                  adc_rst;
  logic                  adc_valid;
  logic [NCH*BW-1:0]     adc_data;
  logic [NCH*4-1:0]      pn_seq_sel;
  logic [NCH-1:0]        err_cnt_clr;
  logic [NCH-1:0]        pn_err;
  logic [NCH-1:0]        pn_oos;
  logic [NCH*ECW-1:0]    pn_err_cnt;

  ad_ip_jesd204_tpl_adc_pn_check #(
    .NUM_CHANNELS    (NCH),
    .DATA_PATH_WIDTH (DPW),
    .CHANNEL_WIDTH   (CW),
    .OOS_THRESHOLD   (TH),
    .ERR_CNT_WIDTH   (ECW)
  ) dut (
    .adc_clk     (adc_clk),
    .adc_rst     (adc_rst),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .pn_seq_sel  (pn_seq_sel),
    .err_cnt_clr (err_cnt_clr),
    .pn_err      (pn_err),
    .pn_oos      (pn_oos),
    .pn_err_cnt  (pn_err_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int nstep  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Stimulus generators (bit 0 = newest generated bit).
  logic [22:0]   gen      [NCH];
  logic [3:0]    gen_mode [NCH];
  logic [BW-1:0] flip     [NCH];
  logic          zero_b   [NCH];
  logic [NCH*4-1:0] sel_next;

  // Reference model state.
  logic [22:0] mh    [NCH];
  logic        mhv   [NCH];
  logic [3:0]  mmode [NCH];
  logic        msync [NCH];
  int          mcnt  [NCH];
  logic        merr  [NCH];
  logic        moos  [NCH];
  int          mec   [NCH];

  typedef struct packed {
    logic [NCH-1:0] cmp;
    logic [NCH-1:0] match;
  } s1_t;
  s1_t sbq[$];

  function automatic logic mode_ok(input logic [3:0] m);
    return (m == 4'h0) || (m == 4'h1);
  endfunction

  task automatic gen_beat(input int ch, output logic [BW-1:0] bt);
    logic nb;
    for (int i = 0; i < BW; i++) begin
      nb = (gen_mode[ch] == 4'h0) ? (gen[ch][8] ^ gen[ch][4]) : (gen[ch][22] ^ gen[ch][17]);
      gen[ch] = {gen[ch][21:0], nb};
      bt[i] = nb;
    end
  endtask

  task automatic mode_restart(input int ch);
    msync[ch] = 1'b0;
    mcnt[ch]  = 0;
    merr[ch]  = 1'b0;
    moos[ch]  = 1'b1;
    mhv[ch]   = 1'b0;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      mode_restart(ch);
      mh[ch]    = '0;
      mec[ch]   = 0;
      mmode[ch] = sel_next[ch*4 +: 4];
    end
    sbq.delete();
  endtask

  // Serial self-synchronising check of one beat against received history.
  task automatic model_s1(input int ch, input logic [BW-1:0] bt, output logic cmp, output logic match);
    logic p;
    match = (bt != '0);
    for (int i = 0; i < BW; i++) begin
      p = (mmode[ch] == 4'h0) ? (mh[ch][8] ^ mh[ch][4]) : (mh[ch][22] ^ mh[ch][17]);
      if (p != bt[i]) match = 1'b0;
      mh[ch] = {mh[ch][21:0], bt[i]};
    end
    cmp     = mhv[ch] && mode_ok(mmode[ch]);
    mhv[ch] = mode_ok(mmode[ch]);
  endtask

  task automatic model_s2(input int ch, input logic cmp, input logic match);
    if (!mode_ok(mmode[ch])) begin
      mode_restart(ch);
      mhv[ch] = 1'b0;
    end else if (!cmp) begin
      merr[ch] = 1'b0;
    end else if (!msync[ch]) begin
      merr[ch] = 1'b0;
      if (!match) mcnt[ch] = 0;
      else if (mcnt[ch] == TH - 1) begin
        msync[ch] = 1'b1; mcnt[ch] = 0; moos[ch] = 1'b0;
      end else mcnt[ch]++;
    end else begin
      merr[ch] = !match;
      if (match) mcnt[ch] = 0;
      else begin
        if (mec[ch] < EC_MAX) mec[ch]++;
        if (mcnt[ch] == TH - 1) begin
          msync[ch] = 1'b0; mcnt[ch] = 0; moos[ch] = 1'b1;
        end else mcnt[ch]++;
      end
    end
  endtask

  task automatic step(input logic v, input logic [NCH-1:0] clr);
    logic [BW-1:0] bt [NCH];
    logic          mchg [NCH];
    s1_t           pend, nxt, head;
    logic          c, m;
    @(negedge adc_clk);
    adc_valid   = v;
    err_cnt_clr = clr;
    pn_seq_sel  = sel_next;
    for (int ch = 0; ch < NCH; ch++) begin
      if (v) begin
        gen_beat(ch, bt[ch]);
        bt[ch] = zero_b[ch] ? '0 : (bt[ch] ^ flip[ch]);
      end else begin
        bt[ch] = BW'($urandom);
      end
      for (int i = 0; i < BW; i++)
        adc_data[ch*BW + (i / CW) * CW + (CW - 1 - (i % CW))] = bt[ch][i];
      flip[ch]   = '0;
      zero_b[ch] = 1'b0;
    end
    @(posedge adc_clk);
    #1;
    nstep++;
    if (adc_rst) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < NCH; ch++) mchg[ch] = (sel_next[ch*4 +: 4] != mmode[ch]);
      if (v) begin
        pend = (sbq.size() > 0) ? sbq.pop_front() : '0;
        nxt  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
          if (mchg[ch]) begin
            mode_restart(ch);
          end else begin
            model_s2(ch, pend.cmp[ch], pend.match[ch]);
            model_s1(ch, bt[ch], c, m);
            nxt.cmp[ch]   = c;
            nxt.match[ch] = m;
          end
        end
        sbq.push_back(nxt);
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (mchg[ch]) begin
            mode_restart(ch);
            if (sbq.size() > 0) begin
              head = sbq[0]; head.cmp[ch] = 1'b0; sbq[0] = head;
            end
          end
        end
      end
      for (int ch = 0; ch < NCH; ch++) begin
        mmode[ch] = sel_next[ch*4 +: 4];
        if (clr[ch]) mec[ch] = 0;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      check_val($sformatf("s%0d oos%0d", nstep, ch), 32'(pn_oos[ch]), 32'(moos[ch]));
      check_val($sformatf("s%0d err%0d", nstep, ch), 32'(pn_err[ch]), 32'(merr[ch]));
      check_val($sformatf("s%0d cnt%0d", nstep, ch), 32'(pn_err_cnt[ch*ECW +: ECW]), 32'(mec[ch]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [13:0] vpat;
    adc_rst     = 1'b1;
    adc_valid   = 1'b0;
    adc_data    = '0;
    err_cnt_clr = '0;
    sel_next    = 8'h10;
    pn_seq_sel  = sel_next;
    gen[0] = 23'h0001FF; gen_mode[0] = 4'h0;
    gen[1] = 23'h7FFFFF; gen_mode[1] = 4'h1;
    for (int ch = 0; ch < NCH; ch++) begin
      flip[ch] = '0; zero_b[ch] = 1'b0;
    end

    step(1'b0, '0);
    step(1'b0, '0);
    adc_rst = 1'b0;
    check_val("rst_oos", 32'(pn_oos), 32'h3);
    check_val("rst_err", 32'(pn_err), 32'h0);
    check_val("rst_cnt", 32'(pn_err_cnt), 32'h0);

    // Lock: beat 1 loads history, beats 2..5 compared, flag drops one beat later.
    for (int i = 0; i < 5; i++) step(1'b1, '0);
    check_val("t1_oos_b5", 32'(pn_oos), 32'h3);
    step(1'b1, '0);
    check_val("t1_lock", 32'(pn_oos), 32'h0);
    check_val("t1_cnt", 32'(pn_err_cnt), 32'h0);
    step(1'b1, '0);

    // Single flipped bit early in the beat.
    flip[0] = 32'h8;
    step(1'b1, '0);
    step(1'b1, '0);
    check_val("t2_err", 32'(pn_err[0]), 32'h1);
    step(1'b1, '0);
    check_val("t2_err_once", 32'(pn_err[0]), 32'h0);
    check_val("t2_cnt", 32'(pn_err_cnt[ECW-1:0]), 32'h1);
    check_val("t2_oos", 32'(pn_oos[0]), 32'h0);

    // Four all-zero beats drop sync.
    for (int i = 0; i < 4; i++) begin
      zero_b[0] = 1'b1;
      step(1'b1, '0);
    end
    step(1'b1, '0);
    check_val("t3_oos", 32'(pn_oos[0]), 32'h1);
    check_val("t3_cnt", 32'(pn_err_cnt[ECW-1:0]), 32'h5);
    for (int i = 0; i < 8; i++) step(1'b1, '0);
    check_val("t3_relock", 32'(pn_oos[0]), 32'h0);

    // Alternating errored/good beats keep sync while the counter saturates.
    for (int i = 0; i < 14; i++) begin
      flip[0] = 32'h8;
      step(1'b1, '0);
      step(1'b1, '0);
    end
    check_val("t4_sat", 32'(pn_err_cnt[ECW-1:0]), 32'(EC_MAX));
    flip[0] = 32'h8;
    step(1'b1, '0);
    step(1'b1, 2'b01);
    check_val("t4_clr_err", 32'(pn_err[0]), 32'h1);
    check_val("t4_clr_cnt", 32'(pn_err_cnt[ECW-1:0]), 32'h0);
    step(1'b1, '0);

    // Switch ch1 from PN23 to PN9.
    sel_next[7:4] = 4'h0; gen_mode[1] = 4'h0; gen[1] = 23'h0001FF;
    step(1'b0, '0);
    check_val("t5_ch1_oos", 32'(pn_oos[1]), 32'h1);
    check_val("t5_ch0_oos", 32'(pn_oos[0]), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, '0);
    check_val("t5_ch1_b5", 32'(pn_oos[1]), 32'h1);
    step(1'b1, '0);
    check_val("t5_ch1_relock", 32'(pn_oos[1]), 32'h0);

    // Disabled mode on ch1, then back to PN23.
    sel_next[7:4] = 4'h5;
    step(1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    check_val("dis_oos", 32'(pn_oos[1]), 32'h1);
    sel_next[7:4] = 4'h1; gen_mode[1] = 4'h1; gen[1] = 23'h7FFFFF;
    step(1'b0, '0);

    // Gapped valid, then a reset in the middle of the stream.
    vpat = 14'b11011010010111;
    for (int i = 0; i < 14; i++) step(vpat[i], '0);
    for (int i = 0; i < 6; i++) step(1'b1, '0);
    check_val("t6_locked", 32'(pn_oos), 32'h0);
    adc_rst = 1'b1;
    step(1'b1, '0);
    adc_rst = 1'b0;
    check_val("t6_rst_oos", 32'(pn_oos), 32'h3);
    check_val("t6_rst_cnt", 32'(pn_err_cnt), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, '0);
    check_val("t6_b5", 32'(pn_oos), 32'h3);
    step(1'b1, '0);
    check_val("t6_relock", 32'(pn_oos), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
